fixedpoint_divider: RTL

Sequential signed divider that inverts `fixedpoint_multiplier`. It takes a full-width signed product and a signed narrow divisor and returns the truncated quotient, the remainder and status flags, so `fixedpoint_divider(a*b, b)` returns `a`. It is a radix-2 restoring long divider with fixed latency and a valid/ready handshake on both sides. It sits in the MulAdd accumulate datapath wherever an accumulated product must be rescaled.

---
 rtl/fixedpoint_divider.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fixedpoint_divider.sv
// Sequential signed restoring divider: full-width dividend by narrow divisor,
// truncating toward zero, with saturation and divide-by-zero flags.
module fixedpoint_divider #(
  parameter int WIDTH_INPUT  = 16,
  parameter int WIDTH_OUTPUT = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [WIDTH_OUTPUT-1:0] dividend_i,
  input  logic [WIDTH_INPUT-1:0]  divisor_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [WIDTH_INPUT-1:0]  quotient_o,
  output logic [WIDTH_INPUT-1:0]  remainder_o,
  output logic                    overflow_o,
  output logic                    div_zero_o
);

  localparam int WI    = WIDTH_INPUT;
  localparam int WO    = WIDTH_OUTPUT;
  localparam int CNT_W = $clog2(WIDTH_INPUT + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  // Most positive / most negative representable quotient.
  function automatic logic [WI-1:0] sat_limit(input logic neg);
    return neg ? {1'b1, {(WI-1){1'b0}}} : {1'b0, {(WI-1){1'b1}}};
  endfunction

  function automatic logic [WI-1:0] apply_sign(input logic [WI-1:0] mag, input logic neg);
    return neg ? (~mag + WI'(1)) : mag;
  endfunction

  function automatic logic quot_ovf(input logic [WI-1:0] mag, input logic neg);
    return neg ? (mag[WI-1] && (|mag[WI-2:0])) : mag[WI-1];
  endfunction

  logic signed [WO-1:0] dividend_s;
  logic signed [WI:0]   divisor_s;
  logic [WO-1:0]        n_abs;
  logic [WI:0]          d_abs;
  logic                 early_ovf;

  assign dividend_s = dividend_i;
  assign divisor_s  = {divisor_i[WI-1], divisor_i};
  assign n_abs      = dividend_s[WO-1] ? (~dividend_i + WO'(1)) : dividend_i;
  assign d_abs      = divisor_s[WI] ? (~divisor_s + (WI+1)'(1)) : divisor_s;
  assign early_ovf  = {1'b0, n_abs} >= {d_abs, {WI{1'b0}}};

  // Operands captured at accept (_p0), iteration state (_p1).
  logic [WI-1:0]    n_low_p0;
  logic [WI:0]      d_mag_p0;
  logic             q_neg_p0;
  logic             r_neg_p0;
  logic             zero_p0;
  logic             eovf_p0;
  logic [WI:0]      rem_p1;
  logic [WI-1:0]    quo_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [WI+1:0]    trial;
  logic [WI+1:0]    diff;
  logic             take;
  logic             last_step;

  assign trial     = {rem_p1, n_low_p0[WI-1]};
  assign diff      = trial - {1'b0, d_mag_p0};
  assign take      = trial >= {1'b0, d_mag_p0};
  assign last_step = (cnt_p1 == CNT_W'(WI - 1));

  logic [WI-1:0] q_fix;
  logic [WI-1:0] r_fix;
  logic          ovf_fix;
  logic          dz_fix;

  // Zero divisor beats overflow; overflow beats the iterated result.
  always_comb begin
    q_fix   = apply_sign(quo_p1, q_neg_p0);
    r_fix   = apply_sign(rem_p1[WI-1:0], r_neg_p0);
    ovf_fix = 1'b0;
    dz_fix  = 1'b0;
    if (zero_p0) begin
      q_fix  = sat_limit(r_neg_p0);
      r_fix  = '0;
      dz_fix = 1'b1;
    end else if (eovf_p0 || quot_ovf(quo_p1, q_neg_p0)) begin
      q_fix   = sat_limit(q_neg_p0);
      r_fix   = '0;
      ovf_fix = 1'b1;
    end
  end

  assign ready_o = (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = CALC;
      CALC:    if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_low_p0    <= '0;
      d_mag_p0    <= '0;
      q_neg_p0    <= 1'b0;
      r_neg_p0    <= 1'b0;
      zero_p0     <= 1'b0;
      eovf_p0     <= 1'b0;
      rem_p1      <= '0;
      quo_p1      <= '0;
      cnt_p1      <= '0;
      valid_o     <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      overflow_o  <= 1'b0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state_q)
        // Accept: the upper half of |N| seeds the partial remainder, so the
        // WI steps consume only the lower half.
        IDLE: if (valid_i) begin
          n_low_p0 <= n_abs[WI-1:0];
          d_mag_p0 <= d_abs;
          q_neg_p0 <= dividend_s[WO-1] ^ divisor_s[WI];
          r_neg_p0 <= dividend_s[WO-1];
          zero_p0  <= (divisor_i == '0);
          eovf_p0  <= early_ovf;
          rem_p1   <= {1'b0, n_abs[WO-1:WI]};
          quo_p1   <= '0;
          cnt_p1   <= '0;
        end
        // One restoring step per cycle.
        CALC: begin
          rem_p1   <= take ? diff[WI:0] : trial[WI:0];
          quo_p1   <= {quo_p1[WI-2:0], take};
          n_low_p0 <= {n_low_p0[WI-2:0], 1'b0};
          cnt_p1   <= cnt_p1 + CNT_W'(1);
        end
        // Result registers only change here.
        FIX: begin
          quotient_o  <= q_fix;
          remainder_o <= r_fix;
          overflow_o  <= ovf_fix;
          div_zero_o  <= dz_fix;
          valid_o     <= 1'b1;
        end
        DONE: if (ready_i) valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
